// File: rtl/sched_in_pkt_fifo.sv
// sched_in_pkt_fifo: store-and-forward packet FIFO placed after the scheduler-input
// AXIS switch. A packet is visible on M_AXIS only after its tlast word has been
// accepted. A packet that would overflow the whole buffer is dropped and reported.
// Optional statistics: define SCHED_IN_PKT_FIFO_STATS_EN to get pkt_count/drop_count.
module sched_in_pkt_fifo #(
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                S_AXIS_tvalid,
    output logic                S_AXIS_tready,
    input  logic [63:0]         S_AXIS_tdata,
    input  logic [ID_WIDTH-1:0] S_AXIS_tid,
    input  logic                S_AXIS_tlast,
    output logic                M_AXIS_tvalid,
    input  logic                M_AXIS_tready,
    output logic [63:0]         M_AXIS_tdata,
    output logic [ID_WIDTH-1:0] M_AXIS_tid,
    output logic                M_AXIS_tlast,
`ifdef SCHED_IN_PKT_FIFO_STATS_EN
    output logic [31:0]         pkt_count,
    output logic [31:0]         drop_count,
`endif
    output logic                pkt_dropped
);
    localparam int DATA_WIDTH = 64;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
    localparam int PW         = DEPTH_LOG2 + 1;
    localparam int WW         = ID_WIDTH + 1 + DATA_WIDTH;

    typedef enum logic {WR_PKT, WR_DROP} wr_state_t;

    wr_state_t       state, state_nxt;
    logic [PW-1:0]   wr_ptr, commit_ptr, rd_ptr, fe_ptr;
    logic [PW-1:0]   used, uncommitted;
    logic            in_en;
    logic            s_hs, wr_acc, commit_evt, drop_evt;
    logic [WW-1:0]   mem [DEPTH];

    // Read pipeline: rv = RAM read in flight, ov = output register, sv = skid entry
    logic            rv, ov, sv;
    logic [WW-1:0]   rdata, odata, sdata;
    logic [1:0]      cnt;
    logic            m_hs, issue;

    // rd_ptr counts words handed over on M_AXIS, so words parked in the output
    // stage still occupy their RAM slot; fe_ptr is the RAM fetch address.
    assign used        = wr_ptr - rd_ptr;
    assign uncommitted = wr_ptr - commit_ptr;
    assign s_hs        = S_AXIS_tvalid && S_AXIS_tready;
    assign wr_acc      = (state == WR_PKT) && s_hs;
    assign commit_evt  = wr_acc && S_AXIS_tlast;

    // Write FSM next-state, input ready and drop detection
    always_comb begin
        state_nxt     = state;
        S_AXIS_tready = 1'b0;
        drop_evt      = 1'b0;
        if (in_en) begin
            case (state)
                WR_PKT: begin
                    S_AXIS_tready = (used != PW'(DEPTH));
                    if (s_hs && !S_AXIS_tlast && uncommitted == PW'(DEPTH - 1))
                        state_nxt = WR_DROP;
                end
                default: begin
                    S_AXIS_tready = 1'b1;
                    if (s_hs && S_AXIS_tlast) begin
                        drop_evt  = 1'b1;
                        state_nxt = WR_PKT;
                    end
                end
            endcase
        end
    end

    // Write FSM state, write/commit pointers and drop pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= WR_PKT;
            in_en       <= 1'b0;
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            pkt_dropped <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_en       <= 1'b1;
            pkt_dropped <= drop_evt;
            if (wr_acc) begin
                if (S_AXIS_tlast) begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    commit_ptr <= wr_ptr + 1'b1;
                end else if (uncommitted == PW'(DEPTH - 1)) begin
                    // Packet fills the whole buffer without tlast: discard it
                    wr_ptr <= commit_ptr;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
        end
    end

    // Packet RAM write (no reset, plain storage)
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= {S_AXIS_tid, S_AXIS_tlast, S_AXIS_tdata};
    end

    // Keep at most two words beyond the RAM (in flight + out + skid) for full rate
    assign cnt   = 2'(rv) + 2'(ov) + 2'(sv);
    assign m_hs  = ov && M_AXIS_tready;
    assign issue = (fe_ptr != commit_ptr) && ((cnt != 2'd2) || m_hs);

    // Read pipeline: RAM fetch, output register with one skid entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fe_ptr <= '0;
            rd_ptr <= '0;
            rv     <= 1'b0;
            ov     <= 1'b0;
            sv     <= 1'b0;
            rdata  <= '0;
            odata  <= '0;
            sdata  <= '0;
        end else begin
            rv <= issue;
            if (issue) begin
                rdata  <= mem[fe_ptr[DEPTH_LOG2-1:0]];
                fe_ptr <= fe_ptr + 1'b1;
            end
            if (m_hs)
                rd_ptr <= rd_ptr + 1'b1;
            if (!ov || m_hs) begin
                if (sv) begin
                    odata <= sdata;
                    ov    <= 1'b1;
                    sv    <= rv;
                    if (rv)
                        sdata <= rdata;
                end else if (rv) begin
                    odata <= rdata;
                    ov    <= 1'b1;
                end else begin
                    ov <= 1'b0;
                end
            end else if (rv) begin
                sdata <= rdata;
                sv    <= 1'b1;
            end
        end
    end

    assign M_AXIS_tvalid = ov;
    assign M_AXIS_tdata  = odata[DATA_WIDTH-1:0];
    assign M_AXIS_tlast  = odata[DATA_WIDTH];
    assign M_AXIS_tid    = odata[WW-1:DATA_WIDTH+1];

`ifdef SCHED_IN_PKT_FIFO_STATS_EN
    // Saturating committed / dropped packet counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_count  <= '0;
            drop_count <= '0;
        end else begin
            if (commit_evt && pkt_count != '1)
                pkt_count <= pkt_count + 1'b1;
            if (drop_evt && drop_count != '1)
                drop_count <= drop_count + 1'b1;
        end
    end
`else
    logic unused_commit;
    assign unused_commit = commit_evt;
`endif

endmodule
